// File: rtl/color_sensor_seq.sv
// TCS3200-class colour sensor sequencer.
// Gates sensor edges per R/G/B filter and picks the dominant colour.
module color_sensor_seq #(
  parameter int unsigned GATE_CYCLES   = 1000000,
  parameter int unsigned SETTLE_CYCLES = 1000,
  parameter int unsigned CNT_W         = 16,
  parameter logic [1:0]  SCALE         = 2'b11,
  parameter int unsigned MIN_COUNT     = 64,
  parameter int unsigned MARGIN_SH     = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             sensorFreq,
  output logic [1:0]       scale,
  output logic [1:0]       filter,
  output logic             enf,
  output logic [2:0]       color,
  output logic [CNT_W-1:0] red_cnt,
  output logic [CNT_W-1:0] green_cnt,
  output logic [CNT_W-1:0] blue_cnt,
  output logic             valid
);

  localparam int unsigned TMAX =
    (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
  localparam int unsigned TW = $clog2(TMAX + 1);

  localparam logic [TW-1:0] GATE_LD   = TW'(GATE_CYCLES - 1);
  localparam logic [TW-1:0] SETTLE_LD = TW'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W:0] MINC     = (CNT_W+1)'(MIN_COUNT);

  localparam logic [1:0] F_RED   = 2'b00;
  localparam logic [1:0] F_GREEN = 2'b11;
  localparam logic [1:0] F_BLUE  = 2'b01;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_GATE,
    S_STORE,
    S_CLASSIFY
  } state_t;

  state_t           state_q;
  logic [1:0]       ch_q;
  logic [TW-1:0]    tmr_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] r_q;
  logic [CNT_W-1:0] g_q;
  logic [CNT_W-1:0] b_q;
  logic [1:0]       filter_q;
  logic             enf_q;
  logic [2:0]       color_q;
  logic [CNT_W-1:0] red_q;
  logic [CNT_W-1:0] green_q;
  logic [CNT_W-1:0] blue_q;
  logic             valid_q;
  logic [2:0]       sync_q;
  logic             pulse;

  logic [CNT_W-1:0] mx_w;
  logic [CNT_W-1:0] sc_w;
  logic [2:0]       oh_w;
  logic [CNT_W:0]   thr_w;
  logic [2:0]       color_d;

  assign scale     = SCALE;
  assign filter    = filter_q;
  assign enf       = enf_q;
  assign color     = color_q;
  assign red_cnt   = red_q;
  assign green_cnt = green_q;
  assign blue_cnt  = blue_q;
  assign valid     = valid_q;

  // Two-flop synchroniser plus a delay flop for rising-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[1:0], sensorFreq};
    end
  end

  assign pulse = sync_q[1] & ~sync_q[2];

  // Pick max and runner-up, then apply floor and margin tests.
  always_comb begin
    mx_w    = r_q;
    sc_w    = g_q;
    oh_w    = 3'b001;
    if (r_q >= g_q && r_q >= b_q) begin
      mx_w = r_q;
      sc_w = (g_q >= b_q) ? g_q : b_q;
      oh_w = 3'b001;
    end else if (g_q >= b_q) begin
      mx_w = g_q;
      sc_w = (r_q >= b_q) ? r_q : b_q;
      oh_w = 3'b100;
    end else begin
      mx_w = b_q;
      sc_w = (r_q >= g_q) ? r_q : g_q;
      oh_w = 3'b010;
    end
    thr_w   = {1'b0, sc_w} + {1'b0, (sc_w >> MARGIN_SH)};
    color_d = 3'b000;
    if ({1'b0, mx_w} >= MINC &&
        {1'b0, mx_w} >= thr_w &&
        mx_w > sc_w) begin
      color_d = oh_w;
    end
  end

  // Frame sequencer: settle, gate, store per channel, then classify.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      ch_q     <= 2'd0;
      tmr_q    <= '0;
      cnt_q    <= '0;
      r_q      <= '0;
      g_q      <= '0;
      b_q      <= '0;
      filter_q <= F_RED;
      enf_q    <= 1'b0;
      color_q  <= 3'b000;
      red_q    <= '0;
      green_q  <= '0;
      blue_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (run) begin
            state_q  <= S_SETTLE;
            ch_q     <= 2'd0;
            filter_q <= F_RED;
            enf_q    <= 1'b1;
            tmr_q    <= SETTLE_LD;
            cnt_q    <= '0;
          end
        end
        S_SETTLE: begin
          if (tmr_q == '0) begin
            state_q <= S_GATE;
            tmr_q   <= GATE_LD;
          end else begin
            tmr_q <= tmr_q - TW'(1);
          end
        end
        S_GATE: begin
          if (pulse && cnt_q != '1) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
          if (tmr_q == '0) begin
            state_q <= S_STORE;
          end else begin
            tmr_q <= tmr_q - TW'(1);
          end
        end
        S_STORE: begin
          case (ch_q)
            2'd0:    r_q <= cnt_q;
            2'd1:    g_q <= cnt_q;
            default: b_q <= cnt_q;
          endcase
          if (ch_q == 2'd2) begin
            state_q <= S_CLASSIFY;
          end else begin
            state_q  <= S_SETTLE;
            ch_q     <= ch_q + 2'd1;
            filter_q <= (ch_q == 2'd0) ? F_GREEN : F_BLUE;
            tmr_q    <= SETTLE_LD;
            cnt_q    <= '0;
          end
        end
        S_CLASSIFY: begin
          color_q  <= color_d;
          red_q    <= r_q;
          green_q  <= g_q;
          blue_q   <= b_q;
          valid_q  <= 1'b1;
          ch_q     <= 2'd0;
          filter_q <= F_RED;
          if (run) begin
            state_q <= S_SETTLE;
            tmr_q   <= SETTLE_LD;
            cnt_q   <= '0;
          end else begin
            state_q <= S_IDLE;
            enf_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_color_sensor_seq.sv
// Directed bench for color_sensor_seq.
// Two instances: 8-bit counts and 5-bit counts for saturation.
`timescale 1ns/1ps
module tb_color_sensor_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       run = 1'b0;
  logic       runB = 1'b0;
  logic       sfA = 1'b0;
  logic       sfB = 1'b0;

  logic [1:0] scaleA, filterA;
  logic       enfA, validA;
  logic [2:0] colorA;
  logic [7:0] rA, gA, bA;

  logic [1:0] scaleB, filterB;
  logic       enfB, validB;
  logic [2:0] colorB;
  logic [4:0] rB, gB, bB;

  int per_r = 4;
  int per_g = 10;
  int per_b = 10;

  int n_cmp = 0;
  int n_bad = 0;
  int vcntA = 0;

  color_sensor_seq #(
    .GATE_CYCLES(100), .SETTLE_CYCLES(4), .CNT_W(8),
    .SCALE(2'b11), .MIN_COUNT(5), .MARGIN_SH(2)
  ) u_a (
    .clk(clk), .rst_n(rst_n), .run(run), .sensorFreq(sfA),
    .scale(scaleA), .filter(filterA), .enf(enfA), .color(colorA),
    .red_cnt(rA), .green_cnt(gA), .blue_cnt(bA), .valid(validA)
  );

  color_sensor_seq #(
    .GATE_CYCLES(100), .SETTLE_CYCLES(4), .CNT_W(5),
    .SCALE(2'b11), .MIN_COUNT(5), .MARGIN_SH(2)
  ) u_b (
    .clk(clk), .rst_n(rst_n), .run(runB), .sensorFreq(sfB),
    .scale(scaleB), .filter(filterB), .enf(enfB), .color(colorB),
    .red_cnt(rB), .green_cnt(gB), .blue_cnt(bB), .valid(validB)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (validA) vcntA <= vcntA + 1;
  end

  // Sensor A: period in clk cycles chosen by the current filter.
  initial begin
    int h;
    #2;
    forever begin
      case (filterA)
        2'b00:   h = per_r * 5;
        2'b11:   h = per_g * 5;
        default: h = per_b * 5;
      endcase
      #(h);
      sfA = ~sfA;
    end
  end

  // Sensor B: red/green period 20, blue period 2.
  initial begin
    int h;
    #2;
    forever begin
      h = (filterB == 2'b01) ? 10 : 100;
      #(h);
      sfB = ~sfB;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_enf(output int ok);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (enfA) begin
        ok = 1;
        return;
      end
    end
  endtask

  // Cycles from enf rising to valid; -1 if not seen.
  task automatic lat_a(output int n);
    n = 0;
    while (n < 400) begin
      @(posedge clk);
      #1;
      n++;
      if (validA) return;
    end
    n = -1;
  endtask

  task automatic wait_va(output int ok);
    ok = 0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #1;
      if (validA) begin
        ok = 1;
        return;
      end
    end
  endtask

  initial begin
    int ok;
    int n;
    int got;
    int v0;
    logic [1:0] f50, f150, f250;

    #1 rst_n = 1'b0;
    run = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("rst_enf", 32'(enfA), 0);
    chk("rst_filter", 32'(filterA), 0);
    chk("rst_scale", 32'(scaleA), 3);
    chk("rst_color", 32'(colorA), 0);
    chk("rst_red_cnt", 32'(rA), 0);
    chk("rst_valid", 32'(validA), 0);
    chk("rst_no_valid", 32'(vcntA), 0);

    // Frame 1: red dominant.
    @(negedge clk);
    rst_n = 1'b1;
    wait_enf(ok);
    chk("f1_enf_rise", 32'(ok), 1);
    n = 0;
    got = 0;
    f50 = 2'bxx;
    f150 = 2'bxx;
    f250 = 2'bxx;
    while (n < 400 && got == 0) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 50) f50 = filterA;
      if (n == 150) f150 = filterA;
      if (n == 250) f250 = filterA;
      if (validA) got = 1;
    end
    chk("f1_latency", 32'(n), 316);
    chk("f1_filter_red", 32'(f50), 32'd0);
    chk("f1_filter_green", 32'(f150), 32'd3);
    chk("f1_filter_blue", 32'(f250), 32'd1);
    chk($sformatf("f1_red_cnt=%0d in 24..26", rA),
        32'(rA >= 24 && rA <= 26), 1);
    chk($sformatf("f1_green_cnt=%0d in 9..11", gA),
        32'(gA >= 9 && gA <= 11), 1);
    chk($sformatf("f1_blue_cnt=%0d in 9..11", bA),
        32'(bA >= 9 && bA <= 11), 1);
    chk("f1_color", 32'(colorA), 32'd1);
    @(posedge clk);
    #1;
    chk("f1_valid_one_cycle", 32'(validA), 0);
    chk("f1_color_hold", 32'(colorA), 32'd1);

    // Frame 2: drop run during green gate.
    ok = 0;
    for (int i = 0; i < 300 && ok == 0; i++) begin
      @(posedge clk);
      #1;
      if (filterA == 2'b11) ok = 1;
    end
    chk("rd_green_seen", 32'(ok), 1);
    repeat (60) @(posedge clk);
    @(negedge clk);
    run = 1'b0;
    v0 = vcntA;
    wait_va(ok);
    chk("rd_valid_seen", 32'(ok), 1);
    chk("rd_color", 32'(colorA), 32'd1);
    chk("rd_enf_off", 32'(enfA), 0);
    chk("rd_filter_red", 32'(filterA), 0);
    repeat (400) @(posedge clk);
    #1;
    chk("rd_one_valid", 32'(vcntA - v0), 1);
    chk("rd_idle_enf", 32'(enfA), 0);

    // Ambiguous: equal period 8 on every filter.
    per_r = 8;
    per_g = 8;
    per_b = 8;
    repeat (20) @(posedge clk);
    @(negedge clk);
    run = 1'b1;
    wait_enf(ok);
    chk("amb_enf_rise", 32'(ok), 1);
    lat_a(n);
    chk("amb_latency", 32'(n), 316);
    chk($sformatf("amb_red_cnt=%0d in 12..13", rA),
        32'(rA >= 12 && rA <= 13), 1);
    chk($sformatf("amb_green_cnt=%0d in 12..13", gA),
        32'(gA >= 12 && gA <= 13), 1);
    chk($sformatf("amb_blue_cnt=%0d in 12..13", bA),
        32'(bA >= 12 && bA <= 13), 1);
    chk("amb_color", 32'(colorA), 0);
    @(negedge clk);
    run = 1'b0;
    wait_va(ok);
    chk("amb_tail_valid", 32'(ok), 1);
    repeat (5) @(posedge clk);

    // Reset pulse in the middle of the red gate.
    per_r = 4;
    per_g = 10;
    per_b = 10;
    repeat (20) @(posedge clk);
    @(negedge clk);
    run = 1'b1;
    wait_enf(ok);
    chk("rg_enf_rise", 32'(ok), 1);
    repeat (50) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rg_enf", 32'(enfA), 0);
    chk("rg_filter", 32'(filterA), 0);
    chk("rg_red_cnt", 32'(rA), 0);
    chk("rg_color", 32'(colorA), 0);
    chk("rg_valid", 32'(validA), 0);
    v0 = vcntA;
    @(negedge clk);
    rst_n = 1'b1;
    wait_enf(ok);
    chk("rg_enf_again", 32'(ok), 1);
    lat_a(n);
    chk("rg_latency", 32'(n), 316);
    chk("rg_valid_count", 32'(vcntA - v0), 0);
    chk("rg_color_red", 32'(colorA), 32'd1);
    @(negedge clk);
    run = 1'b0;

    // Narrow counter: blue saturates at 31.
    @(negedge clk);
    runB = 1'b1;
    ok = 0;
    for (int i = 0; i < 400 && ok == 0; i++) begin
      @(posedge clk);
      #1;
      if (validB) ok = 1;
    end
    chk("sat_valid_seen", 32'(ok), 1);
    chk("sat_blue_cnt", 32'(bB), 31);
    chk("sat_color", 32'(colorB), 32'd2);
    chk($sformatf("sat_red_cnt=%0d in 4..6", rB),
        32'(rB >= 4 && rB <= 6), 1);
    runB = 1'b0;
    repeat (10) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
